johnson_run_ctrl: RTL and testbench
===================================

# johnson_run_ctrl

Run/step controller for the 3-bit Johnson counter datapath.
- Owns a programmable prescaler, a command FSM (run / stop / single-step), direction control and a 6-state Johnson register.
- Drives the board's 8-bit active-low seven-segment display with the current state index 0–5.
- Sits between the board push-button/switch logic and the display, replacing the free-running counter with a sequenced one.

## Interface
Parameters:
- DIV_W, 8, width of prescaler compare value and prescaler register
- WC_W, 8, width of wrap counter

Ports:
- inClk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-low
- start  input  1  start continuous run (level sampled each cycle)
- stop  input  1  stop run, return to idle
- step  input  1  single advance request when idle
- dir  input  1  0 = forward, 1 = reverse
- div  input  DIV_W  advance period minus one, in cycles
- cntr  output  3  Johnson state
- Seven_Seg  output  8  active-low segments {dp,g,f,e,d,c,b,a}
- busy  output  1  1 while in RUN
- wrap  output  1  one-cycle pulse when cntr enters 000 through an advance
- wrap_cnt  output  WC_W  number of wraps, modulo 2^WC_W

## Operation
- Forward advance: cntr <= {cntr[1:0], ~cntr[2]}, giving 000→001→011→111→110→100→000.
- Reverse advance: cntr <= {~cntr[0], cntr[2:1]}, giving 000→100→110→111→011→001→000.
- Index map, with digit code:
  - 000 = 0 (C0)
  - 001 = 1 (F9)
  - 011 = 2 (A4)
  - 111 = 3 (B0)
  - 110 = 4 (99)
  - 100 = 5 (92)
  - dp is always 1 (off).
- The illegal codes 010 and 101 are unreachable. If either is ever present, the next advance forces 000 and no wrap is signalled.
- FSM states:
  - **IDLE:** busy=0.
    - stop: ignored.
    - start=1: go to RUN, presc <= 0.
    - else step=1: go to STEP.
    - start and step together: start wins.
  - **STEP:** advance once at the end of this cycle, then go to IDLE. All command inputs are ignored in this cycle.
  - **RUN:** busy=1.
    - stop=1: go to IDLE, presc <= 0, no advance this cycle even if a tick is due.
    - start and stop together: stop wins.
    - step: ignored.
    - Otherwise: if presc >= div, advance and presc <= 0; else presc <= presc+1.
- dir and div are sampled on every cycle and take effect at the next compare or advance.
- The >= compare means lowering div mid-run never overruns the count.
- wrap and wrap_cnt:
  - wrap is asserted in the same cycle that cntr first shows 000 after an advance.
  - wrap_cnt increments on that edge and wraps to 0 after 2^WC_W−1.
- Reset values, applied on a rising edge with rst=0 and overriding all inputs:
  - state = IDLE, cntr = 000, presc = 0
  - busy = 0, wrap = 0, wrap_cnt = 0
  - Seven_Seg = 8'hC0 (8'hFF when the seven-seg decoder is compiled out)

## Timing
- All outputs are registered; no combinational input-to-output path.
- Seven_Seg is registered from the next-state value of cntr, so it always matches cntr in the same cycle.
- Run timing:
  - start sampled at edge E0: busy=1 after E0.
  - First advance is visible after edge E0+div+1.
  - Subsequent advances every div+1 cycles.
  - div=0 gives one advance per cycle.
- Step timing: step sampled at edge E0 (in IDLE) → cntr changes after E0+1, busy stays 0.
- Stop timing: stop sampled at edge E0 → busy=0 after E0 and cntr holds its value from before E0.
- Reset mid-run or mid-step: all registers take reset values after that edge. After release the block waits in IDLE even if start is held; start is sampled from the first cycle with rst=1.

## Configuration
- Macro: JOHNSON_SEVEN_SEG_EN.
- Defined: the index decoder and the Seven_Seg register are built as specified above.
- Undefined: no decoder logic and Seven_Seg is tied to 8'hFF (display blank). All other behaviour is identical.

## Test plan
- **Reset:** rst=0 for 5 cycles with start=1 → cntr=000, Seven_Seg=C0, busy=0, wrap=0, wrap_cnt=0, and it stays IDLE for the first cycle after release.
- **Forward run:** div=0, dir=0, start pulse → on consecutive cycles:
  - cntr 001, 011, 111, 110, 100, 000
  - Seven_Seg F9, A4, B0, 99, 92, C0
  - wrap high only with 000; wrap_cnt=1
- **Prescaled run and stop:** div=3, start → an advance every 4 cycles. stop on the cycle a tick is due → no advance, busy=0, cntr frozen for 20 further cycles.
- **Reverse step:** from 000 with dir=1, step pulse → cntr=100, Seven_Seg=92 after 2 edges, busy=0 throughout. A second step → 110. step and start in the same cycle → RUN.
- **Reset mid-run:** run with div=0 reaches 111, then rst=0 for one cycle → cntr=000, wrap_cnt=0, busy=0 on the next cycle.
- **Macro undefined:** repeat the forward-run scenario → identical cntr, wrap and busy sequence, with Seven_Seg constant FF.

Source files
------------

// File: rtl/johnson_run_ctrl.sv
// Run/step controller for a 6-state Johnson counter with prescaled advance and wrap counting.
// Define JOHNSON_SEVEN_SEG_EN to build the seven-segment index decoder; otherwise Seven_Seg is blanked.
module johnson_run_ctrl #(
  parameter int DIV_W = 8,
  parameter int WC_W  = 8
) (
  input  logic             inClk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             dir,
  input  logic [DIV_W-1:0] div,
  output logic [2:0]       cntr,
  output logic [7:0]       Seven_Seg,
  output logic             busy,
  output logic             wrap,
  output logic [WC_W-1:0]  wrap_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  presc_q, presc_d;
  logic [2:0]        cntr_q, cntr_d;
  logic [2:0]        adv_val_s;
  logic              adv_s;
  logic              wrap_d;
  logic              busy_q;
  logic              wrap_q;
  logic [WC_W-1:0]   wrap_cnt_q;

  // Illegal codes 010/101 collapse to 000 on the next advance.
  function automatic logic [2:0] johnson_next(input logic [2:0] c, input logic rev);
    if ((c == 3'b010) || (c == 3'b101)) begin
      return 3'b000;
    end else if (rev) begin
      return {~c[0], c[2:1]};
    end else begin
      return {c[1:0], ~c[2]};
    end
  endfunction

  function automatic logic is_legal(input logic [2:0] c);
    return (c != 3'b010) && (c != 3'b101);
  endfunction

`ifdef JOHNSON_SEVEN_SEG_EN
  logic [7:0] seg_q;

  function automatic logic [7:0] seg_decode(input logic [2:0] c);
    case (c)
      3'b000:  return 8'hC0;
      3'b001:  return 8'hF9;
      3'b011:  return 8'hA4;
      3'b111:  return 8'hB0;
      3'b110:  return 8'h99;
      3'b100:  return 8'h92;
      default: return 8'hFF;
    endcase
  endfunction
`endif

  // Command FSM next state, prescaler and advance decision.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    adv_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          presc_d = {DIV_W{1'b0}};
        end else if (step) begin
          state_d = S_STEP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STEP: begin
        adv_s   = 1'b1;
        state_d = S_IDLE;
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
          presc_d = {DIV_W{1'b0}};
        end else if (presc_q >= div) begin
          adv_s   = 1'b1;
          presc_d = {DIV_W{1'b0}};
        end else begin
          presc_d = presc_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        presc_d = {DIV_W{1'b0}};
      end
    endcase
    adv_val_s = johnson_next(cntr_q, dir);
    if (adv_s) begin
      cntr_d = adv_val_s;
      wrap_d = is_legal(cntr_q) && (adv_val_s == 3'b000);
    end else begin
      cntr_d = cntr_q;
      wrap_d = 1'b0;
    end
  end

  // State and all registered outputs; busy/seg are taken from next-state values to stay aligned.
  always_ff @(posedge inClk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      presc_q    <= {DIV_W{1'b0}};
      cntr_q     <= 3'b000;
      busy_q     <= 1'b0;
      wrap_q     <= 1'b0;
      wrap_cnt_q <= {WC_W{1'b0}};
`ifdef JOHNSON_SEVEN_SEG_EN
      seg_q      <= 8'hC0;
`endif
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      cntr_q     <= cntr_d;
      busy_q     <= (state_d == S_RUN);
      wrap_q     <= wrap_d;
      wrap_cnt_q <= wrap_d ? (wrap_cnt_q + WC_W'(1)) : wrap_cnt_q;
`ifdef JOHNSON_SEVEN_SEG_EN
      seg_q      <= seg_decode(cntr_d);
`endif
    end
  end

  assign cntr     = cntr_q;
  assign busy     = busy_q;
  assign wrap     = wrap_q;
  assign wrap_cnt = wrap_cnt_q;
`ifdef JOHNSON_SEVEN_SEG_EN
  assign Seven_Seg = seg_q;
`else
  assign Seven_Seg = 8'hFF;
`endif

endmodule

// File: tb/tb_johnson_run_ctrl.sv
// Directed self-checking bench for johnson_run_ctrl; expected seven-seg codes follow JOHNSON_SEVEN_SEG_EN.
module tb_johnson_run_ctrl;

  logic       inClk = 1'b0;
  logic       rst, start, stop, step, dir;
  logic [7:0] div;
  logic [2:0] cntr;
  logic [7:0] Seven_Seg;
  logic       busy, wrap;
  logic [7:0] wrap_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 inClk = ~inClk;

  johnson_run_ctrl #(.DIV_W(8), .WC_W(8)) dut (
    .inClk     (inClk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .step      (step),
    .dir       (dir),
    .div       (div),
    .cntr      (cntr),
    .Seven_Seg (Seven_Seg),
    .busy      (busy),
    .wrap      (wrap),
    .wrap_cnt  (wrap_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_seg(input logic [2:0] c);
`ifdef JOHNSON_SEVEN_SEG_EN
    case (c)
      3'b000:  return 8'hC0;
      3'b001:  return 8'hF9;
      3'b011:  return 8'hA4;
      3'b111:  return 8'hB0;
      3'b110:  return 8'h99;
      3'b100:  return 8'h92;
      default: return 8'hFF;
    endcase
`else
    return 8'hFF;
`endif
  endfunction

  task automatic check_state(input string tag, input logic [2:0] ec, input logic eb,
                             input logic ew, input logic [7:0] ewc);
    check_val({tag, ".cntr"}, 32'(cntr), 32'(ec));
    check_val({tag, ".seg"},  32'(Seven_Seg), 32'(exp_seg(ec)));
    check_val({tag, ".busy"}, 32'(busy), 32'(eb));
    check_val({tag, ".wrap"}, 32'(wrap), 32'(ew));
    check_val({tag, ".wcnt"}, 32'(wrap_cnt), 32'(ewc));
  endtask

  task automatic tick;
    @(posedge inClk);
    #1;
  endtask

  initial begin
    logic [2:0] fwd_seq [6];
    logic [2:0] rev_seq [4];
    logic [2:0] e;
    fwd_seq = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000};
    rev_seq = '{3'b111, 3'b011, 3'b001, 3'b000};

    // Reset with start held
    rst = 1'b0; start = 1'b1; stop = 1'b0; step = 1'b0; dir = 1'b0; div = 8'd0;
    repeat (5) tick();
    check_state("reset", 3'b000, 1'b0, 1'b0, 8'd0);
    rst = 1'b1;
    check_val("release_idle", 32'(busy), 32'd0);

    // Forward run at div=0; first rst=1 edge samples start
    tick();
    check_state("run_go", 3'b000, 1'b1, 1'b0, 8'd0);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_state("fwd", fwd_seq[i], 1'b1, (i == 5), (i == 5) ? 8'd1 : 8'd0);
    end
    tick();
    check_state("fwd_after", 3'b001, 1'b1, 1'b0, 8'd1);
    stop = 1'b1;
    tick();
    check_state("stop0", 3'b001, 1'b0, 1'b0, 8'd1);
    stop = 1'b0;

    // Prescaled run, div=3
    div = 8'd3; start = 1'b1;
    tick();
    check_state("presc_go", 3'b001, 1'b1, 1'b0, 8'd1);
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      e = (k < 4) ? 3'b001 : ((k < 8) ? 3'b011 : 3'b111);
      check_state("presc", e, 1'b1, 1'b0, 8'd1);
    end
    repeat (3) begin
      tick();
      check_state("presc_wait", 3'b111, 1'b1, 1'b0, 8'd1);
    end
    // Stop (with start also high) on the cycle a tick is due
    stop = 1'b1; start = 1'b1;
    tick();
    check_state("stop_due", 3'b111, 1'b0, 1'b0, 8'd1);
    stop = 1'b0; start = 1'b0;
    repeat (20) begin
      tick();
      check_state("frozen", 3'b111, 1'b0, 1'b0, 8'd1);
    end

    rst = 1'b0;
    tick();
    check_state("rst2", 3'b000, 1'b0, 1'b0, 8'd0);
    rst = 1'b1;

    // Reverse single steps
    dir = 1'b1; step = 1'b1;
    tick();
    check_state("step_e0", 3'b000, 1'b0, 1'b0, 8'd0);
    step = 1'b0;
    tick();
    check_state("step1", 3'b100, 1'b0, 1'b0, 8'd0);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    check_state("step2", 3'b110, 1'b0, 1'b0, 8'd0);
    step = 1'b1; start = 1'b1;
    tick();
    check_state("step_start", 3'b110, 1'b1, 1'b0, 8'd0);
    step = 1'b0; start = 1'b0; stop = 1'b1;
    tick();
    check_state("stop2", 3'b110, 1'b0, 1'b0, 8'd0);
    stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      check_state("rev_step", rev_seq[i], 1'b0, (i == 3), (i == 3) ? 8'd1 : 8'd0);
    end
    tick();
    check_state("rev_after", 3'b000, 1'b0, 1'b0, 8'd1);

    // Reset mid-run
    dir = 1'b0; div = 8'd0; start = 1'b1;
    tick();
    check_state("mid_go", 3'b000, 1'b1, 1'b0, 8'd1);
    start = 1'b0;
    repeat (3) tick();
    check_state("mid_111", 3'b111, 1'b1, 1'b0, 8'd1);
    rst = 1'b0;
    tick();
    check_state("rst_mid", 3'b000, 1'b0, 1'b0, 8'd0);
    rst = 1'b1;
    tick();
    check_state("post_rst", 3'b000, 1'b0, 1'b0, 8'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
